// File: rtl/mem_access_stage_pkg.sv
// Shared LC-3b types for the MEM stage: datapath word, control word, and FSM states.
package mem_access_stage_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_byte_enable;

  typedef struct packed {
    logic load_regfile;
    logic dmem_read;
    logic dmem_write;
    logic dmem_byte;
    logic dmem_indirect;
  } lc3b_control;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    INDIR,
    DONE
  } mem_state_t;

  function automatic lc3b_word sext8(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

endpackage

// File: rtl/mem_access_stage_align.sv
// Combinational byte-lane steering for data memory: request address, write lanes/data,
// and byte select with sign extension on loads.
module mem_align
  import mem_access_stage_pkg::*;
(
  input  logic [15:0] addr,
  input  logic [15:0] store_data,
  input  logic [15:0] rdata,
  input  logic        is_read,
  input  logic        is_write,
  input  logic        is_byte,
  output logic [15:0] dmem_address,
  output logic [15:0] dmem_wdata,
  output logic [1:0]  dmem_byte_enable,
  output logic [15:0] load_data
);

  logic [7:0] lane;

  always_comb begin
    dmem_address     = '0;
    dmem_wdata       = '0;
    dmem_byte_enable = 2'b00;
    lane             = addr[0] ? rdata[15:8] : rdata[7:0];
    load_data        = is_byte ? sext8(lane) : rdata;

    // Byte accesses keep the full address; word accesses are forced even.
    if (is_read || is_write)
      dmem_address = is_byte ? addr : {addr[15:1], 1'b0};

    if (is_write) begin
      if (is_byte) begin
        dmem_wdata       = {store_data[7:0], store_data[7:0]};
        dmem_byte_enable = addr[0] ? 2'b10 : 2'b01;
      end else begin
        dmem_wdata       = store_data;
        dmem_byte_enable = 2'b11;
      end
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// LC-3b MEM stage: runs LDR/STR/LDB/STB and two-access LDI/STI, stalling upstream until
// the data memory responds, then hands the result to MEM/WB.
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [15:0] alu_in,
  input  logic [15:0] store_data_in,
  input  logic [15:0] curr_ir_in,
  input  logic [15:0] curr_pc_in,
  input  lc3b_control control_word_in,
  input  logic        dmem_resp,
  input  logic [15:0] dmem_rdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [15:0] dmem_address,
  output logic [15:0] dmem_wdata,
  output logic [1:0]  dmem_byte_enable,
  output logic        stall,
  output logic        valid_out,
  output logic [15:0] mem_data_out,
  output logic [15:0] alu_out,
  output logic [15:0] curr_ir_out,
  output logic [15:0] curr_pc_out,
  output lc3b_control control_word_out
);

  mem_state_t state;
  lc3b_word   ptr_reg;
  lc3b_word   data_reg;
  lc3b_word   load_data;
  lc3b_word   acc_addr;
  logic       acc_read;
  logic       acc_write;
  logic       acc_byte;
  logic       memop;
  logic       ind;

  assign ind   = control_word_in.dmem_indirect;
  assign memop = valid_in & (control_word_in.dmem_read | control_word_in.dmem_write);

  // The pointer fetch of LDI/STI is always a word read; byte flag is ignored when indirect.
  always_comb begin
    acc_addr  = '0;
    acc_read  = 1'b0;
    acc_write = 1'b0;
    acc_byte  = 1'b0;
    case (state)
      ACCESS: begin
        acc_addr = alu_in;
        if (ind) begin
          acc_read = 1'b1;
        end else begin
          acc_read  = control_word_in.dmem_read;
          acc_write = control_word_in.dmem_write & ~control_word_in.dmem_read;
          acc_byte  = control_word_in.dmem_byte;
        end
      end
      INDIR: begin
        acc_addr  = ptr_reg;
        acc_read  = control_word_in.dmem_read;
        acc_write = control_word_in.dmem_write & ~control_word_in.dmem_read;
      end
      default: ;
    endcase
  end

  mem_align u_align (
    .addr             (acc_addr),
    .store_data       (store_data_in),
    .rdata            (dmem_rdata),
    .is_read          (acc_read),
    .is_write         (acc_write),
    .is_byte          (acc_byte),
    .dmem_address     (dmem_address),
    .dmem_wdata       (dmem_wdata),
    .dmem_byte_enable (dmem_byte_enable),
    .load_data        (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr_reg  <= '0;
      data_reg <= '0;
    end else begin
      case (state)
        IDLE:
          if (memop) state <= ACCESS;
        ACCESS:
          if (dmem_resp) begin
            if (ind) begin
              ptr_reg <= dmem_rdata;
              state   <= INDIR;
            end else begin
              data_reg <= load_data;
              state    <= DONE;
            end
          end
        INDIR:
          if (dmem_resp) begin
            data_reg <= load_data;
            state    <= DONE;
          end
        DONE:
          state <= IDLE;
        default:
          state <= IDLE;
      endcase
    end
  end

  assign dmem_read        = acc_read;
  assign dmem_write       = acc_write;
  assign stall            = memop & (state != DONE);
  assign valid_out        = (state == DONE) | ((state == IDLE) & valid_in & ~memop);
  assign mem_data_out     = data_reg;
  assign alu_out          = alu_in;
  assign curr_ir_out      = curr_ir_in;
  assign curr_pc_out      = curr_pc_in;
  assign control_word_out = control_word_in;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for the MEM stage: a per-cycle vector table plus hand sequences for
// delayed response, STI and reset during an indirect access.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic [15:0] alu_in = '0;
  logic [15:0] store_data_in = '0;
  logic [15:0] curr_ir_in = '0;
  logic [15:0] curr_pc_in = '0;
  lc3b_control control_word_in = '0;
  logic        dmem_resp = 1'b0;
  logic [15:0] dmem_rdata = '0;
  logic        dmem_read;
  logic        dmem_write;
  logic [15:0] dmem_address;
  logic [15:0] dmem_wdata;
  logic [1:0]  dmem_byte_enable;
  logic        stall;
  logic        valid_out;
  logic [15:0] mem_data_out;
  logic [15:0] alu_out;
  logic [15:0] curr_ir_out;
  logic [15:0] curr_pc_out;
  lc3b_control control_word_out;

  int checks = 0;
  int passed = 0;

  mem_access_stage dut (
    .clk              (clk),
    .reset            (reset),
    .valid_in         (valid_in),
    .alu_in           (alu_in),
    .store_data_in    (store_data_in),
    .curr_ir_in       (curr_ir_in),
    .curr_pc_in       (curr_pc_in),
    .control_word_in  (control_word_in),
    .dmem_resp        (dmem_resp),
    .dmem_rdata       (dmem_rdata),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_address     (dmem_address),
    .dmem_wdata       (dmem_wdata),
    .dmem_byte_enable (dmem_byte_enable),
    .stall            (stall),
    .valid_out        (valid_out),
    .mem_data_out     (mem_data_out),
    .alu_out          (alu_out),
    .curr_ir_out      (curr_ir_out),
    .curr_pc_out      (curr_pc_out),
    .control_word_out (control_word_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [15:0] alu;
    logic [15:0] sd;
    lc3b_control cw;
    logic        resp;
    logic [15:0] rdata;
    logic        e_stall;
    logic        e_valid;
    logic        e_rd;
    logic        e_wr;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;
    logic [1:0]  e_be;
    logic [15:0] e_mem;
    logic        chk_addr;
    logic        chk_mem;
  } vec_t;

  vec_t vecs[16];

  function automatic lc3b_control mkCw(input logic r, input logic w, input logic b, input logic i);
    lc3b_control c;
    c = '0;
    c.load_regfile  = r;
    c.dmem_read     = r;
    c.dmem_write    = w;
    c.dmem_byte     = b;
    c.dmem_indirect = i;
    return c;
  endfunction

  function automatic vec_t mkVec(
    input logic v, input logic [15:0] a, input logic [15:0] s, input lc3b_control c,
    input logic rs, input logic [15:0] rd,
    input logic es, input logic ev, input logic er, input logic ew,
    input logic [15:0] ea, input logic [15:0] ewd, input logic [1:0] eb, input logic [15:0] em,
    input logic ca, input logic cm);
    vec_t x;
    x.valid = v; x.alu = a; x.sd = s; x.cw = c; x.resp = rs; x.rdata = rd;
    x.e_stall = es; x.e_valid = ev; x.e_rd = er; x.e_wr = ew;
    x.e_addr = ea; x.e_wdata = ewd; x.e_be = eb; x.e_mem = em;
    x.chk_addr = ca; x.chk_mem = cm;
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Drive one cycle's inputs on the falling edge; outputs settle before the next rising edge.
  task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] s,
                               input lc3b_control c, input logic rs, input logic [15:0] rd);
    @(negedge clk);
    valid_in        = v;
    alu_in          = a;
    store_data_in   = s;
    control_word_in = c;
    dmem_resp       = rs;
    dmem_rdata      = rd;
    curr_ir_in      = a ^ 16'h5A5A;
    curr_pc_in      = a + 16'h0002;
    #1;
  endtask

  initial begin
    lc3b_control cw_none, cw_ld, cw_ldb, cw_stb, cw_sti, cw_ldi;
    int stall_count;

    cw_none = mkCw(0, 0, 0, 0);
    cw_ld   = mkCw(1, 0, 0, 0);
    cw_ldb  = mkCw(1, 0, 1, 0);
    cw_stb  = mkCw(0, 1, 1, 0);
    cw_sti  = mkCw(0, 1, 0, 1);
    cw_ldi  = mkCw(1, 0, 0, 1);

    vecs[0]  = mkVec(0, 16'h0000, 16'h0000, cw_none, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 1, 1);
    vecs[1]  = mkVec(1, 16'h0042, 16'h0000, cw_none, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 1, 1);
    vecs[2]  = mkVec(1, 16'h1003, 16'h0000, cw_ld,   0, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 1, 1);
    vecs[3]  = mkVec(1, 16'h1003, 16'h0000, cw_ld,   1, 16'hBEEF, 1, 0, 1, 0, 16'h1002, 16'h0000, 2'b00, 16'h0000, 1, 1);
    vecs[4]  = mkVec(1, 16'h1003, 16'h0000, cw_ld,   0, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 2'b00, 16'hBEEF, 1, 1);
    vecs[5]  = mkVec(1, 16'h3000, 16'h12AB, cw_stb,  0, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 16'hBEEF, 1, 1);
    vecs[6]  = mkVec(1, 16'h3000, 16'h12AB, cw_stb,  1, 16'h0000, 1, 0, 0, 1, 16'h3000, 16'hABAB, 2'b01, 16'hBEEF, 1, 1);
    vecs[7]  = mkVec(1, 16'h3000, 16'h12AB, cw_stb,  0, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 1, 0);
    vecs[8]  = mkVec(1, 16'hFFFF, 16'h0000, cw_ldb,  0, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 1, 0);
    vecs[9]  = mkVec(1, 16'hFFFF, 16'h0000, cw_ldb,  1, 16'h7F00, 1, 0, 1, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 0, 0);
    vecs[10] = mkVec(1, 16'hFFFF, 16'h0000, cw_ldb,  0, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 2'b00, 16'h007F, 1, 1);
    vecs[11] = mkVec(0, 16'h0000, 16'h0000, cw_none, 1, 16'h1234, 0, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 16'h007F, 1, 1);
    vecs[12] = mkVec(0, 16'h0000, 16'h0000, cw_none, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 16'h007F, 1, 1);
    vecs[13] = mkVec(1, 16'h3001, 16'h5566, cw_stb,  0, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 16'h007F, 1, 1);
    vecs[14] = mkVec(1, 16'h3001, 16'h5566, cw_stb,  1, 16'h0000, 1, 0, 0, 1, 16'h0000, 16'h6666, 2'b10, 16'h007F, 0, 1);
    vecs[15] = mkVec(1, 16'h3001, 16'h5566, cw_stb,  0, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 1, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].alu, vecs[i].sd, vecs[i].cw, vecs[i].resp, vecs[i].rdata);
      checkOutput($sformatf("row%0d stall", i), {15'b0, stall}, {15'b0, vecs[i].e_stall});
      checkOutput($sformatf("row%0d valid_out", i), {15'b0, valid_out}, {15'b0, vecs[i].e_valid});
      checkOutput($sformatf("row%0d dmem_read", i), {15'b0, dmem_read}, {15'b0, vecs[i].e_rd});
      checkOutput($sformatf("row%0d dmem_write", i), {15'b0, dmem_write}, {15'b0, vecs[i].e_wr});
      checkOutput($sformatf("row%0d wdata", i), dmem_wdata, vecs[i].e_wdata);
      checkOutput($sformatf("row%0d byte_enable", i), {14'b0, dmem_byte_enable}, {14'b0, vecs[i].e_be});
      checkOutput($sformatf("row%0d alu_out", i), alu_out, vecs[i].alu);
      checkOutput($sformatf("row%0d ir_out", i), curr_ir_out, vecs[i].alu ^ 16'h5A5A);
      if (vecs[i].chk_addr)
        checkOutput($sformatf("row%0d address", i), dmem_address, vecs[i].e_addr);
      if (vecs[i].chk_mem)
        checkOutput($sformatf("row%0d mem_data", i), mem_data_out, vecs[i].e_mem);
    end

    // LDB with the response arriving on the fourth request cycle.
    stall_count = 0;
    applyStimulus(1, 16'h2001, 16'h0000, cw_ldb, 0, 16'h0000);
    stall_count += int'(stall);
    checkOutput("ldb idle read", {15'b0, dmem_read}, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 16'h2001, 16'h0000, cw_ldb, (k == 3), (k == 3) ? 16'h80FF : 16'h0000);
      stall_count += int'(stall);
      checkOutput($sformatf("ldb wait%0d read", k), {15'b0, dmem_read}, 16'h0001);
      checkOutput($sformatf("ldb wait%0d write", k), {15'b0, dmem_write}, 16'h0000);
      checkOutput($sformatf("ldb wait%0d be", k), {14'b0, dmem_byte_enable}, 16'h0000);
      checkOutput($sformatf("ldb wait%0d valid", k), {15'b0, valid_out}, 16'h0000);
    end
    applyStimulus(1, 16'h2001, 16'h0000, cw_ldb, 0, 16'h0000);
    stall_count += int'(stall);
    checkOutput("ldb done valid", {15'b0, valid_out}, 16'h0001);
    checkOutput("ldb mem_data", mem_data_out, 16'hFF80);
    checkOutput("ldb stall cycles", 16'(stall_count), 16'd5);

    // STI: pointer read, then word write through the even-aligned pointer.
    stall_count = 0;
    applyStimulus(1, 16'h4000, 16'hCAFE, cw_sti, 0, 16'h0000);
    stall_count += int'(stall);
    applyStimulus(1, 16'h4000, 16'hCAFE, cw_sti, 1, 16'h5001);
    stall_count += int'(stall);
    checkOutput("sti ptr read", {15'b0, dmem_read}, 16'h0001);
    checkOutput("sti ptr write", {15'b0, dmem_write}, 16'h0000);
    checkOutput("sti ptr addr", dmem_address, 16'h4000);
    applyStimulus(1, 16'h4000, 16'hCAFE, cw_sti, 1, 16'h0000);
    stall_count += int'(stall);
    checkOutput("sti final write", {15'b0, dmem_write}, 16'h0001);
    checkOutput("sti final read", {15'b0, dmem_read}, 16'h0000);
    checkOutput("sti final addr", dmem_address, 16'h5000);
    checkOutput("sti final be", {14'b0, dmem_byte_enable}, 16'h0003);
    checkOutput("sti final wdata", dmem_wdata, 16'hCAFE);
    applyStimulus(1, 16'h4000, 16'hCAFE, cw_sti, 0, 16'h0000);
    stall_count += int'(stall);
    checkOutput("sti done valid", {15'b0, valid_out}, 16'h0001);
    checkOutput("sti stall cycles", 16'(stall_count), 16'd3);

    // LDI interrupted by reset while waiting on the second access.
    applyStimulus(1, 16'h6001, 16'h0000, cw_ldi, 0, 16'h0000);
    applyStimulus(1, 16'h6001, 16'h0000, cw_ldi, 1, 16'h7000);
    checkOutput("ldi ptr addr", dmem_address, 16'h6000);
    applyStimulus(1, 16'h6001, 16'h0000, cw_ldi, 0, 16'h0000);
    checkOutput("ldi indir read", {15'b0, dmem_read}, 16'h0001);
    checkOutput("ldi indir addr", dmem_address, 16'h7000);
    reset    = 1'b1;
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(0, 16'h0000, 16'h0000, cw_none, 0, 16'h0000);
    checkOutput("rst read", {15'b0, dmem_read}, 16'h0000);
    checkOutput("rst stall", {15'b0, stall}, 16'h0000);
    checkOutput("rst valid", {15'b0, valid_out}, 16'h0000);
    checkOutput("rst mem_data", mem_data_out, 16'h0000);
    applyStimulus(0, 16'h0000, 16'h0000, cw_none, 1, 16'h9999);
    checkOutput("rst late resp valid", {15'b0, valid_out}, 16'h0000);
    checkOutput("rst late resp read", {15'b0, dmem_read}, 16'h0000);
    applyStimulus(1, 16'h0042, 16'h0000, cw_none, 0, 16'h0000);
    checkOutput("rst idle passthru valid", {15'b0, valid_out}, 16'h0001);
    checkOutput("rst idle stall", {15'b0, stall}, 16'h0000);
    checkOutput("rst mem_data after resp", mem_data_out, 16'h0000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
